// File: rtl/crc_pkg.sv
// Shared CRC-32 definitions used by both the checker and the generator.
package crc_pkg;

    localparam int CRC_W = 32;
    localparam int DIV_W = 2 * CRC_W;
    localparam int STEP_CNT_W = 5;
    localparam logic [CRC_W-1:0] CRC32_POLY = 32'h04C11DB7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } crc_state_e;

endpackage

// File: rtl/crc32_div_step.sv
// One bit of modulo-2 long division: shift the dividend left and subtract the
// polynomial whenever the bit leaving the top was set.
module crc32_div_step
    import crc_pkg::*;
(
    input  logic [DIV_W-1:0] d_i,
    input  logic [CRC_W-1:0] poly_i,
    output logic [DIV_W-1:0] d_o
);

    assign d_o = {d_i[DIV_W-2:0], 1'b0}
               ^ (d_i[DIV_W-1] ? {poly_i, {CRC_W{1'b0}}} : {DIV_W{1'b0}});

endmodule

// File: rtl/crc32_check.sv
// Bit-serial CRC-32 checker: divides {message, received CRC} over 32 cycles and
// reports the syndrome, a pass flag and a saturating mismatch counter.
module crc32_check
    import crc_pkg::*;
#(
    parameter logic [CRC_W-1:0] POLY  = CRC32_POLY,
    parameter int               CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [31:0]      message_i,
    input  logic [31:0]      crc_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             match_o,
    output logic [31:0]      syndrome_o,
    output logic [CNT_W-1:0] err_count_o,
    input  logic             clear_i
);

    localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [STEP_CNT_W-1:0] LAST_STEP = 5'd31;

    crc_state_e            state_q;
    logic [STEP_CNT_W-1:0] count_q;
    logic [DIV_W-1:0]      dividend_q;
    logic [DIV_W-1:0]      dividend_step_s;
    logic                  match_q;
    logic [CRC_W-1:0]      syndrome_q;
    logic [CNT_W-1:0]      err_cnt_q;
    logic [CNT_W-1:0]      err_cnt_d;
    logic                  last_step_s;
    logic                  mismatch_s;

    crc32_div_step u_step (
        .d_i    (dividend_q),
        .poly_i (POLY),
        .d_o    (dividend_step_s)
    );

    assign last_step_s = (state_q == SHIFT) && (count_q == LAST_STEP);
    assign mismatch_s  = (dividend_step_s[DIV_W-1 -: CRC_W] != {CRC_W{1'b0}});

    // Clear has priority over a coincident increment; the count sticks at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clear_i) begin
            err_cnt_d = {CNT_W{1'b0}};
        end else if (last_step_s && mismatch_s && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_ONE;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Handshake FSM, dividend shifter and result registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            count_q    <= {STEP_CNT_W{1'b0}};
            dividend_q <= {DIV_W{1'b0}};
            match_q    <= 1'b0;
            syndrome_q <= {CRC_W{1'b0}};
            err_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            err_cnt_q <= err_cnt_d;
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        dividend_q <= {message_i, crc_i};
                        count_q    <= {STEP_CNT_W{1'b0}};
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    dividend_q <= dividend_step_s;
                    if (count_q == LAST_STEP) begin
                        syndrome_q <= dividend_step_s[DIV_W-1 -: CRC_W];
                        match_q    <= !mismatch_s;
                        count_q    <= {STEP_CNT_W{1'b0}};
                        state_q    <= RESP;
                    end else begin
                        count_q <= count_q + 5'd1;
                    end
                end
                RESP: begin
                    if (ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_o     = (state_q == IDLE);
    assign valid_o     = (state_q == RESP);
    assign match_o     = match_q;
    assign syndrome_o  = syndrome_q;
    assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_crc32_check.sv
// Scoreboard bench for crc32_check: directed vectors push expected results, a
// negedge monitor pops them on each result handshake.
module tb_crc32_check;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] MAXC = {CNT_W{1'b1}};

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             valid_i;
    logic             ready_o;
    logic [31:0]      message_i;
    logic [31:0]      crc_i;
    logic             valid_o;
    logic             ready_i;
    logic             match_o;
    logic [31:0]      syndrome_o;
    logic [CNT_W-1:0] err_count_o;
    logic             clear_i;

    typedef struct packed {
        logic             m;
        logic [31:0]      s;
        logic [CNT_W-1:0] c;
    } exp_t;

    exp_t             exp_q[$];
    int               n_cmp = 0;
    int               n_err = 0;
    logic [CNT_W-1:0] model_cnt = '0;

    crc32_check #(.POLY(32'h04C11DB7), .CNT_W(CNT_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .message_i   (message_i),
        .crc_i       (crc_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .match_o     (match_o),
        .syndrome_o  (syndrome_o),
        .err_count_o (err_count_o),
        .clear_i     (clear_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every completed result handshake must match the oldest expectation.
    always @(negedge clk_i) begin
        if (rst_i === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("match_o", {63'd0, match_o}, {63'd0, e.m});
                chk("syndrome_o", {32'd0, syndrome_o}, {32'd0, e.s});
                chk("err_count_o", {{(64-CNT_W){1'b0}}, err_count_o}, {{(64-CNT_W){1'b0}}, e.c});
            end
        end
    end

    // Issue one request; entered and left #1 after a rising edge.
    task automatic run(input logic [31:0] msg, input logic [31:0] crc,
                       input logic [31:0] exp_syn, input bit clr, input bit hold);
        int   cycles;
        exp_t e;
        cycles = 0;
        while (!ready_o && cycles < 100) begin
            @(posedge clk_i); #1;
            cycles++;
        end
        chk("ready_before_issue", {63'd0, ready_o}, 64'd1);
        if (clr) model_cnt = '0;
        else if (exp_syn != 32'd0 && model_cnt != MAXC) model_cnt = model_cnt + 1'b1;
        e.m = (exp_syn == 32'd0);
        e.s = exp_syn;
        e.c = model_cnt;
        exp_q.push_back(e);
        ready_i   = !hold;
        valid_i   = 1'b1;
        message_i = msg;
        crc_i     = crc;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        cycles  = 0;
        while (!valid_o && cycles < 40) begin
            @(posedge clk_i); #1;
            cycles++;
            if (clr && cycles == 31) clear_i = 1'b1;
        end
        clear_i = 1'b0;
        chk("latency", 64'(cycles), 64'd32);
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                chk("hold_valid_o", {63'd0, valid_o}, 64'd1);
                chk("hold_ready_o", {63'd0, ready_o}, 64'd0);
                chk("hold_syndrome", {32'd0, syndrome_o}, {32'd0, exp_syn});
                chk("hold_match", {63'd0, match_o}, {63'd0, e.m});
                valid_i   = 1'b1;
                message_i = 32'h12345678 + 32'(i);
                crc_i     = 32'h0;
                @(posedge clk_i); #1;
            end
            valid_i = 1'b0;
            ready_i = 1'b1;
        end
        @(posedge clk_i); #1;
        chk("ready_after_handshake", {63'd0, ready_o}, 64'd1);
        chk("valid_after_handshake", {63'd0, valid_o}, 64'd0);
    endtask

    // Start a request and assert reset at shift cycle 15; no result may appear.
    task automatic run_reset_mid_shift();
        bit seen;
        valid_i   = 1'b1;
        message_i = 32'h00000001;
        crc_i     = 32'h00000000;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (15) begin
            @(posedge clk_i); #1;
        end
        rst_i = 1'b0;
        #1;
        model_cnt = '0;
        chk("rst_ready_o", {63'd0, ready_o}, 64'd1);
        chk("rst_valid_o", {63'd0, valid_o}, 64'd0);
        chk("rst_match_o", {63'd0, match_o}, 64'd0);
        chk("rst_syndrome_o", {32'd0, syndrome_o}, 64'd0);
        chk("rst_err_count_o", {{(64-CNT_W){1'b0}}, err_count_o}, 64'd0);
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk_i); #1;
            if (valid_o) seen = 1'b1;
        end
        chk("no_result_after_reset", {63'd0, seen}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i     = 1'b0;
        valid_i   = 1'b0;
        ready_i   = 1'b1;
        clear_i   = 1'b0;
        message_i = 32'h0;
        crc_i     = 32'h0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_ready_o", {63'd0, ready_o}, 64'd1);
        chk("reset_valid_o", {63'd0, valid_o}, 64'd0);
        chk("reset_match_o", {63'd0, match_o}, 64'd0);
        chk("reset_syndrome_o", {32'd0, syndrome_o}, 64'd0);
        chk("reset_err_count_o", {{(64-CNT_W){1'b0}}, err_count_o}, 64'd0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        run(32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0);
        run(32'h00000001, 32'h04C11DB7, 32'h00000000, 1'b0, 1'b0);
        run(32'h00000001, 32'h00000000, 32'h04C11DB7, 1'b0, 1'b0);
        run(32'h00000002, 32'h09823B6E, 32'h00000000, 1'b0, 1'b0);
        run(32'h00000002, 32'h09823B6F, 32'h00000001, 1'b0, 1'b0);
        run(32'h00000004, 32'h130476DC, 32'h00000000, 1'b0, 1'b0);
        run(32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0);
        run(32'h00000002, 32'h09823B6F, 32'h00000001, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            run(32'h00000000, 32'h00000003 + 32'(i), 32'h00000003 + 32'(i), 1'b0, 1'b0);
        end
        run(32'h00000001, 32'h00000000, 32'h04C11DB7, 1'b1, 1'b0);
        run(32'h00000000, 32'h00000005, 32'h00000005, 1'b0, 1'b0);
        run_reset_mid_shift();
        run(32'h00000001, 32'h04C11DB7, 32'h00000000, 1'b0, 1'b0);
        run(32'h00000001, 32'h00000000, 32'h04C11DB7, 1'b0, 1'b0);

        repeat (2) @(posedge clk_i);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
